mux4_sel_reg: RTL and testbench
===============================

Name: mux4_sel_reg

Overview:
- 4-input, WIDTH-bit selector with a 2-bit select split into s1 (MSB) and s0 (LSB).
- Provides a purely combinational output and a registered output with 1-cycle latency.
- Registered output has an enable and a valid flag.
- Used wherever a steered datapath bit or word must be either used same-cycle or pipelined.

Parameters:
- WIDTH, 1, bit width of each data input and of both outputs (legal range 1..64).
- RST_VAL, 0, value loaded into y_q on reset (WIDTH bits, zero-extended/truncated).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- i0  in  WIDTH  data input, selected when {s1,s0}=2'b00.
- i1  in  WIDTH  data input, selected when {s1,s0}=2'b01.
- i2  in  WIDTH  data input, selected when {s1,s0}=2'b10.
- i3  in  WIDTH  data input, selected when {s1,s0}=2'b11.
- s0  in  1  select LSB.
- s1  in  1  select MSB.
- en  in  1  capture enable for the registered path.
- y  out  WIDTH  combinational selected data.
- y_q  out  WIDTH  registered selected data.
- y_vld  out  1  high when y_q holds data captured since reset.
- sel_q  out  2  {s1,s0} captured alongside y_q.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. No asynchronous reset anywhere.
- Combinational path, select = {s1,s0}:
  - 00 -> y=i0; 01 -> y=i1; 10 -> y=i2; 11 -> y=i3.
  - Zero-latency, no clock or reset dependence.
  - y follows any input or select change within the same delta/cycle.
- X/Z handling: if s1 or s0 is X/Z, y is X in simulation. No priority fallback is implemented.
- Registered path, per rising clk edge, highest priority first:
  - rst=1: y_q <= RST_VAL, sel_q <= 2'b00, y_vld <= 0. Overrides en.
  - else en=1: y_q <= y (as computed from pre-edge inputs), sel_q <= {s1,s0}, y_vld <= 1.
  - else: y_q, sel_q and y_vld hold.
- Latency: y_q reflects inputs sampled at edge N, visible after edge N; exactly 1 cycle.
- y_vld stays 1 until the next reset; it is not cleared by en=0.
- Reset asserted mid-stream: the first edge with rst=1 clears the registers. Capture resumes on the first edge with rst=0 and en=1.
- Reset has no effect on the combinational output y.
- Select and data may change every cycle, including simultaneously; no glitch filtering is required.
- Width rule: every bit lane is selected identically. No sign or width extension is done inside the block.

Decomposition:
- Shared package mux4_pkg:
  - sel_t 2-bit typedef.
  - Constants SEL_I0=2'b00, SEL_I1=2'b01, SEL_I2=2'b10, SEL_I3=2'b11.
- One combinational sub-module, mux4_core (WIDTH param, inputs i0..i3 and sel, output y). It is instantiated once.
- Top-level mux4_sel_reg holds the y_q, sel_q and y_vld registers.

Test Plan:
- Exhaustive select, WIDTH=1: i0=0,i1=1,i2=0,i3=1; sweep {s1,s0} 00,01,10,11 -> y=0,1,0,1 with no clock edge needed. Then invert all data -> y=1,0,1,0.
- Toggling stimulus: i0..i3 start at 0 and toggle every 40/20/10/5 time units; s0 toggles every 2, s1 every 1. Over 100 units, y always equals the input indexed by {s1,s0}; checked on every change.
- Registered latency, WIDTH=8:
  - Set i2=8'hA5, {s1,s0}=10, en=1 -> after next edge y_q=8'hA5, sel_q=2'b10, y_vld=1.
  - Change i2 to 8'h3C with en=0 -> y=8'h3C immediately, y_q stays 8'hA5.
- Reset: RST_VAL=8'h5A; hold rst=1 with en=1 for 2 edges -> y_q=8'h5A, sel_q=00, y_vld=0. y still tracks inputs.
- Reset mid-operation: after valid capture (y_q=8'hFF), assert rst for one edge -> y_q=8'h5A, y_vld=0. Release rst with en=1, i0=8'h11, sel=00 -> next edge y_q=8'h11, y_vld=1.
- Back-to-back captures: en=1 every cycle, select cycling 00->01->10->11 with i0..i3=1,2,3,4 -> y_q sequence 1,2,3,4, each one cycle after the select is applied.

Source files
------------

// File: rtl/mux4_pkg.sv
// Shared select encoding for the 4-way selector and its registered wrapper.
package mux4_pkg;
    typedef logic [1:0] sel_t;

    localparam sel_t SEL_I0 = 2'b00;
    localparam sel_t SEL_I1 = 2'b01;
    localparam sel_t SEL_I2 = 2'b10;
    localparam sel_t SEL_I3 = 2'b11;
endpackage

// File: rtl/mux4_sel_reg_if.sv
// Data/select/enable bundle between a producer and the selector block.
interface mux4_sel_reg_if
    import mux4_pkg::*;
#(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] i0, i1, i2, i3;
    logic             s0, s1, en;
    logic [WIDTH-1:0] y, y_q;
    logic             y_vld;
    sel_t             sel_q;

    modport master (
        output i0, i1, i2, i3, s0, s1, en,
        input  y, y_q, y_vld, sel_q
    );

    modport slave (
        input  i0, i1, i2, i3, s0, s1, en,
        output y, y_q, y_vld, sel_q
    );
endinterface

// File: rtl/mux4_core.sv
// Purely combinational 4:1 word selector; every bit lane steered identically.
module mux4_core
    import mux4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  sel_t             sel,
    output logic [WIDTH-1:0] y
);
    // An unknown select falls to default so simulation shows X instead of a guess.
    always_comb begin
        y = 'x;
        case (sel)
            SEL_I0:  y = i0;
            SEL_I1:  y = i1;
            SEL_I2:  y = i2;
            SEL_I3:  y = i3;
            default: y = 'x;
        endcase
    end
endmodule

// File: rtl/mux4_sel_reg.sv
// 4:1 selector with a same-cycle output and an enabled 1-cycle registered copy.
module mux4_sel_reg
    import mux4_pkg::*;
#(
    parameter int          WIDTH   = 1,
    parameter logic [63:0] RST_VAL = 64'd0
) (
    input logic          clk,
    input logic          rst,
    mux4_sel_reg_if.slave bus
);
    sel_t             sel;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    sel_t             sel_q;
    logic             y_vld;

    assign sel = {bus.s1, bus.s0};

    mux4_core #(.WIDTH(WIDTH)) u_core (
        .i0  (bus.i0),
        .i1  (bus.i1),
        .i2  (bus.i2),
        .i3  (bus.i3),
        .sel (sel),
        .y   (y)
    );

    // y_vld is sticky: once anything is captured it stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= RST_VAL[WIDTH-1:0];
            sel_q <= SEL_I0;
            y_vld <= 1'b0;
        end else if (bus.en) begin
            y_q   <= y;
            sel_q <= sel;
            y_vld <= 1'b1;
        end
    end

    assign bus.y     = y;
    assign bus.y_q   = y_q;
    assign bus.sel_q = sel_q;
    assign bus.y_vld = y_vld;
endmodule

// File: tb/tb_mux4_sel_reg.sv
// Directed checks of the selector: WIDTH=1 combinational sweeps, WIDTH=8 registered path.
`timescale 1ns/1ps
module tb_mux4_sel_reg;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mux4_sel_reg_if #(.WIDTH(1)) b1 ();
    mux4_sel_reg_if #(.WIDTH(8)) b8 ();

    mux4_sel_reg #(.WIDTH(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    mux4_sel_reg #(.WIDTH(8), .RST_VAL(64'h5A)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_select_w1();
        logic [3:0] pat;
        logic [3:0] exp_y;
        pat   = 4'b1010;
        exp_y = 4'b1010;
        b1.i0 = pat[0]; b1.i1 = pat[1]; b1.i2 = pat[2]; b1.i3 = pat[3];
        for (int s = 0; s < 4; s++) begin
            {b1.s1, b1.s0} = s[1:0];
            #1;
            checks++;
            if (b1.y !== exp_y[s]) begin
                errors++;
                $display("FAIL sel_w1 s=%0d y=%b exp=%b", s, b1.y, exp_y[s]);
            end
        end
        b1.i0 = ~pat[0]; b1.i1 = ~pat[1]; b1.i2 = ~pat[2]; b1.i3 = ~pat[3];
        exp_y = 4'b0101;
        for (int s = 0; s < 4; s++) begin
            {b1.s1, b1.s0} = s[1:0];
            #1;
            checks++;
            if (b1.y !== exp_y[s]) begin
                errors++;
                $display("FAIL sel_w1_inv s=%0d y=%b exp=%b", s, b1.y, exp_y[s]);
            end
        end
    endtask

    task automatic test_toggle_w1();
        logic [3:0] d;
        logic [1:0] s;
        for (int t = 0; t < 100; t++) begin
            d[0] = 1'((t / 40) % 2);
            d[1] = 1'((t / 20) % 2);
            d[2] = 1'((t / 10) % 2);
            d[3] = 1'((t / 5) % 2);
            s[0] = 1'((t / 2) % 2);
            s[1] = 1'(t % 2);
            b1.i0 = d[0]; b1.i1 = d[1]; b1.i2 = d[2]; b1.i3 = d[3];
            b1.s0 = s[0]; b1.s1 = s[1];
            #1;
            checks++;
            if (b1.y !== d[s]) begin
                errors++;
                $display("FAIL toggle t=%0d y=%b exp=%b", t, b1.y, d[s]);
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        b8.en = 1'b1;
        b8.i0 = 8'h01; b8.i1 = 8'h02; b8.i2 = 8'h77; b8.i3 = 8'h04;
        b8.s1 = 1'b1; b8.s0 = 1'b0;
        edge_settle();
        edge_settle();
        checks++;
        if (b8.y_q !== 8'h5A) begin
            errors++; $display("FAIL reset_yq got=%h exp=5a", b8.y_q);
        end
        checks++;
        if (b8.sel_q !== 2'b00) begin
            errors++; $display("FAIL reset_selq got=%b exp=00", b8.sel_q);
        end
        checks++;
        if (b8.y_vld !== 1'b0) begin
            errors++; $display("FAIL reset_vld got=%b exp=0", b8.y_vld);
        end
        checks++;
        if (b8.y !== 8'h77) begin
            errors++; $display("FAIL reset_y_comb got=%h exp=77", b8.y);
        end
    endtask

    task automatic test_latency();
        rst   = 1'b0;
        b8.i2 = 8'hA5;
        b8.s1 = 1'b1; b8.s0 = 1'b0;
        b8.en = 1'b1;
        #1;
        checks++;
        if (b8.y_q !== 8'h5A) begin
            errors++; $display("FAIL lat_pre_edge got=%h exp=5a", b8.y_q);
        end
        edge_settle();
        checks++;
        if (b8.y_q !== 8'hA5) begin
            errors++; $display("FAIL lat_yq got=%h exp=a5", b8.y_q);
        end
        checks++;
        if (b8.sel_q !== 2'b10) begin
            errors++; $display("FAIL lat_selq got=%b exp=10", b8.sel_q);
        end
        checks++;
        if (b8.y_vld !== 1'b1) begin
            errors++; $display("FAIL lat_vld got=%b exp=1", b8.y_vld);
        end
        b8.en = 1'b0;
        b8.i2 = 8'h3C;
        #1;
        checks++;
        if (b8.y !== 8'h3C) begin
            errors++; $display("FAIL hold_y_comb got=%h exp=3c", b8.y);
        end
        b8.s1 = 1'b0; b8.s0 = 1'b1;
        edge_settle();
        checks++;
        if (b8.y_q !== 8'hA5) begin
            errors++; $display("FAIL hold_yq got=%h exp=a5", b8.y_q);
        end
        checks++;
        if (b8.sel_q !== 2'b10) begin
            errors++; $display("FAIL hold_selq got=%b exp=10", b8.sel_q);
        end
        checks++;
        if (b8.y_vld !== 1'b1) begin
            errors++; $display("FAIL hold_vld got=%b exp=1", b8.y_vld);
        end
    endtask

    task automatic test_mid_reset();
        b8.i3 = 8'hFF;
        b8.s1 = 1'b1; b8.s0 = 1'b1;
        b8.en = 1'b1;
        edge_settle();
        checks++;
        if (b8.y_q !== 8'hFF) begin
            errors++; $display("FAIL mid_capture got=%h exp=ff", b8.y_q);
        end
        rst = 1'b1;
        edge_settle();
        checks++;
        if (b8.y_q !== 8'h5A || b8.y_vld !== 1'b0 || b8.sel_q !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset yq=%h vld=%b selq=%b exp 5a/0/00", b8.y_q, b8.y_vld, b8.sel_q);
        end
        rst   = 1'b0;
        b8.i0 = 8'h11;
        b8.s1 = 1'b0; b8.s0 = 1'b0;
        edge_settle();
        checks++;
        if (b8.y_q !== 8'h11 || b8.y_vld !== 1'b1) begin
            errors++;
            $display("FAIL mid_resume yq=%h vld=%b exp 11/1", b8.y_q, b8.y_vld);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] prev;
        b8.i0 = 8'd1; b8.i1 = 8'd2; b8.i2 = 8'd3; b8.i3 = 8'd4;
        b8.en = 1'b1;
        prev  = 8'h11;
        for (int k = 0; k < 4; k++) begin
            {b8.s1, b8.s0} = k[1:0];
            #1;
            checks++;
            if (b8.y_q !== prev) begin
                errors++; $display("FAIL b2b_pre k=%0d got=%h exp=%h", k, b8.y_q, prev);
            end
            edge_settle();
            checks++;
            if (b8.y_q !== 8'(k + 1) || b8.sel_q !== k[1:0]) begin
                errors++;
                $display("FAIL b2b k=%0d yq=%h selq=%b exp %h/%b", k, b8.y_q, b8.sel_q, 8'(k + 1), k[1:0]);
            end
            prev = 8'(k + 1);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        b1.i0 = '0; b1.i1 = '0; b1.i2 = '0; b1.i3 = '0;
        b1.s0 = 1'b0; b1.s1 = 1'b0; b1.en = 1'b0;
        b8.i0 = '0; b8.i1 = '0; b8.i2 = '0; b8.i3 = '0;
        b8.s0 = 1'b0; b8.s1 = 1'b0; b8.en = 1'b0;
        #2;
        test_select_w1();
        test_toggle_w1();
        @(negedge clk);
        test_reset();
        test_latency();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
